aoi_bist_controller: RTL and testbench

//  Built-in self-test sequencer for the 5-input AND-OR-INVERT cell, y = ~((x1&x2)|(x3&x4&x5)).
//  On a start pulse it drives all 32 input vectors into the cell under test and samples its output.
//  It compares each sample against an internal golden model, counts mismatches and reports pass/fail.
//  It sits between the test-mode control logic and one AOI cell instance.

---
 rtl/aoi_bist_controller.sv | 128 ++++++++++++
 tb/tb_aoi_bist_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/aoi_bist_controller.sv
// BIST sequencer for the 5-input AOI cell y = ~((x1&x2)|(x3&x4&x5)): sweeps all 32 vectors and counts mismatches.
// Optional build macro AOI_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module aoi_bist_controller #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 y_dut,
  output logic [4:0]           x_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [4:0]           first_fail
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]     SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t               state_q, state_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [4:0]           x_q, x_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [4:0]           ff_q, ff_d;
  logic                 golden;
  logic                 mismatch;
  logic                 finish_run;

  assign golden = ~((x_q[4] & x_q[3]) | (x_q[2] & x_q[1] & x_q[0]));
  // Case inequality so an X or Z from the cell is scored as a failure.
  assign mismatch = (y_dut !== golden);

`ifdef AOI_BIST_STOP_ON_FAIL_EN
  assign finish_run = mismatch || (x_q == 5'd31);
`else
  assign finish_run = (x_q == 5'd31);
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    x_d      = x_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ff_d     = ff_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = APPLY;
          settle_d = '0;
          x_d      = 5'd0;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          err_d    = '0;
          ff_d     = 5'd0;
        end
      end
      APPLY: begin
        if (settle_q == SET_LAST) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + ERR_CNT_W'(1);
          if (err_q == '0)      ff_d  = x_q;
        end
        if (finish_run) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = APPLY;
          x_d     = x_q + 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      settle_q <= '0;
      x_q      <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ff_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      x_q      <= x_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
    end
  end

  assign x_out      = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_aoi_bist_controller.sv
// Directed bench for aoi_bist_controller: table of fault models with hand-computed results plus reset/restart sequences.
module tb_aoi_bist_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       y_dut;
  logic [4:0] x_out;
  logic       busy, done, pass;
  logic [5:0] err_count;
  logic [4:0] first_fail;

  int n_checks = 0;
  int n_errors = 0;
  int mode = 0;  // 0 golden, 1 stuck-1, 2 stuck-0, 3 X on vector 3, 4 inverted for vectors >= 16

  aoi_bist_controller #(.SETTLE_CYCLES(1), .ERR_CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .y_dut(y_dut),
    .x_out(x_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail)
  );

  always #5 clock = ~clock;

  logic ref_y;
  assign ref_y = ~((x_out[4] & x_out[3]) | (x_out[2] & x_out[1] & x_out[0]));

  always_comb begin
    case (mode)
      1: y_dut = 1'b1;
      2: y_dut = 1'b0;
      3: y_dut = (x_out == 5'd3) ? 1'bx : ref_y;
      4: y_dut = x_out[4] ? ~ref_y : ref_y;
      default: y_dut = ref_y;
    endcase
  end

  typedef struct {
    int mode;
    int lat;
    int err;
    int pss;
    int ff;
    int xo;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulses start for one edge, returns edges from the start edge to the done cycle.
  task automatic run(output int lat, output int busy_ok);
    lat = -1;
    busy_ok = 1;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 0;
    end
  endtask

  initial begin
    int lat, bok;
    int last_busy;

`ifdef AOI_BIST_STOP_ON_FAIL_EN
    tbl[0] = '{0, 64, 0,  1, 0,  31};
    tbl[1] = '{1, 16, 1,  0, 7,  7};
    tbl[2] = '{2, 2,  1,  0, 0,  0};
    tbl[3] = '{3, 8,  1,  0, 3,  3};
    tbl[4] = '{4, 34, 1,  0, 16, 16};
`else
    tbl[0] = '{0, 64, 0,  1, 0,  31};
    tbl[1] = '{1, 64, 11, 0, 7,  31};
    tbl[2] = '{2, 64, 21, 0, 0,  31};
    tbl[3] = '{3, 64, 1,  0, 3,  31};
    tbl[4] = '{4, 64, 16, 0, 16, 31};
`endif

    #12;
    chk("rst_x_out", x_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_fail", first_fail, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run(lat, bok);
      chk($sformatf("t%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("t%0d_busy_during_run", i), bok, 1);
      chk($sformatf("t%0d_busy_at_done", i), busy, 0);
      chk($sformatf("t%0d_err_count", i), err_count, tbl[i].err);
      chk($sformatf("t%0d_pass", i), pass, tbl[i].pss);
      chk($sformatf("t%0d_first_fail", i), first_fail, tbl[i].ff);
      chk($sformatf("t%0d_x_out", i), x_out, tbl[i].xo);
      repeat (3) @(posedge clock);
      #1;
      chk($sformatf("t%0d_done_cleared", i), done, 0);
      chk($sformatf("t%0d_pass_held", i), pass, tbl[i].pss);
      chk($sformatf("t%0d_x_out_held", i), x_out, tbl[i].xo);
    end

    // Start re-pulsed mid-run must be ignored.
    mode = 0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock);
      #1;
      start = (n == 20);
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    chk("repulse_latency", lat, 64);
    chk("repulse_pass", pass, 1);
    @(posedge clock);
    #1;
    chk("repulse_no_requeue", busy, 0);

    // Asynchronous reset mid-run at x_out = 10.
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    last_busy = 0;
    for (int n = 0; n < 100; n++) begin
      if (x_out == 5'd10) break;
      @(posedge clock);
      #1;
    end
    chk("reached_x10", x_out, 10);
    mode = 1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_x_out", x_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_first_fail", first_fail, 0);
    chk("midrst_pass_done", {pass, done}, 0);
    @(negedge clock);
    reset = 1'b0;
    mode = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("postrst_idle", busy, 0);
    run(lat, bok);
    chk("postrst_latency", lat, 64);
    chk("postrst_pass", pass, 1);
    chk("postrst_err_count", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
